// File: rtl/hyperram_if.sv
// Bus bundle between the HyperRAM sequencer and its surroundings: the Avalon-MM
// burst master on one side and the HyperRAM I/O block on the other.
interface hyperram_if #(
    parameter int ADDR_W = 22
);
    // Avalon-MM burst slave side
    logic              avm_write_i;
    logic              avm_read_i;
    logic [ADDR_W-1:0] avm_address_i;
    logic [15:0]       avm_writedata_i;
    logic [1:0]        avm_byteenable_i;
    logic [7:0]        avm_burstcount_i;
    logic              avm_waitrequest_o;
    logic [15:0]       avm_readdata_o;
    logic              avm_readdatavalid_o;
    logic              error_o;

    // HyperRAM I/O block side
    logic              ctrl_rstn_o;
    logic              ctrl_csn_o;
    logic [1:0]        ctrl_ck_ddr_o;
    logic [15:0]       ctrl_dq_ddr_out_o;
    logic              ctrl_dq_oe_o;
    logic [1:0]        ctrl_rwds_ddr_out_o;
    logic              ctrl_rwds_oe_o;
    logic [15:0]       ctrl_dq_ddr_in_i;
    logic              ctrl_dq_ie_i;

    // The sequencer itself
    modport slave (
        input  avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
               avm_byteenable_i, avm_burstcount_i, ctrl_dq_ddr_in_i, ctrl_dq_ie_i,
        output avm_waitrequest_o, avm_readdata_o, avm_readdatavalid_o, error_o,
               ctrl_rstn_o, ctrl_csn_o, ctrl_ck_ddr_o, ctrl_dq_ddr_out_o,
               ctrl_dq_oe_o, ctrl_rwds_ddr_out_o, ctrl_rwds_oe_o
    );

    // Everything around the sequencer (Avalon master plus I/O block)
    modport master (
        output avm_write_i, avm_read_i, avm_address_i, avm_writedata_i,
               avm_byteenable_i, avm_burstcount_i, ctrl_dq_ddr_in_i, ctrl_dq_ie_i,
        input  avm_waitrequest_o, avm_readdata_o, avm_readdatavalid_o, error_o,
               ctrl_rstn_o, ctrl_csn_o, ctrl_ck_ddr_o, ctrl_dq_ddr_out_o,
               ctrl_dq_oe_o, ctrl_rwds_ddr_out_o, ctrl_rwds_oe_o
    );
endinterface

// File: rtl/hyperram_ctrl.sv
// HyperRAM transaction sequencer: turns Avalon-MM read/write bursts into HyperBus
// command-address, fixed 2x latency and data phases for the I/O block.
// Memory-space linear bursts only; RWDS is never used for latency detection.
module hyperram_ctrl #(
    parameter int ADDR_W       = 22,
    parameter int LATENCY      = 4,
    parameter int RESET_CYCLES = 200,
    parameter int RECOVERY     = 2,
    parameter int TIMEOUT      = 64
) (
    input logic       clk_x1_i,
    input logic       rst_i,
    hyperram_if.slave bus
);
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_CA    = 3'd2;
    localparam logic [2:0] ST_LAT   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;
    localparam logic [2:0] ST_RECOV = 3'd6;

    // One shared phase counter; the sum is a safe upper bound for every phase length.
    localparam int CNT_W = $clog2(RESET_CYCLES + TIMEOUT + 2 * LATENCY + RECOVERY);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CA_LAST   = CNT_W'(2);
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(2 * LATENCY - 2);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVERY - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        words_q, words_d;   // words still to transfer on HyperBus
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_read_q, is_read_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic              have_q, have_d;     // wdata_q holds a word not yet clocked out
    logic [15:0]       rdata_q, rdata_d;
    logic              rdv_q, rdv_d;
    logic              err_q, err_d;

    logic [47:0]       ca_w;
    logic              wr_more;

    // Command-address: R/W, memory space, linear burst, row/upper column, lower column.
    assign ca_w = {is_read_q, 1'b0, 1'b1, {(32 - ADDR_W){1'b0}}, addr_q[ADDR_W-1:3],
                   13'b0, addr_q[2:0]};

    // In a write burst the master may still supply words beyond the one already held.
    assign wr_more = (words_q > {7'b0, have_q});

    // Next-state and datapath decisions for the whole sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        have_d    = have_q;
        rdata_d   = rdata_q;
        rdv_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.avm_read_i || bus.avm_write_i) begin
                    state_d   = ST_CA;
                    cnt_d     = '0;
                    addr_d    = bus.avm_address_i;
                    is_read_d = bus.avm_read_i;
                    words_d   = (bus.avm_burstcount_i == 8'd0) ? 8'd1 : bus.avm_burstcount_i;
                    wdata_d   = bus.avm_writedata_i;
                    be_d      = bus.avm_byteenable_i;
                    have_d    = !bus.avm_read_i;
                end
            end
            ST_CA: begin
                if (cnt_q == CA_LAST) begin
                    state_d = ST_LAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LAT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = is_read_q ? ST_READ : ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (have_q) begin
                    words_d = words_q - 1'b1;
                    have_d  = 1'b0;
                    if (words_q == 8'd1) begin
                        state_d = ST_RECOV;
                        cnt_d   = '0;
                    end
                end
                if (bus.avm_write_i && wr_more) begin
                    wdata_d = bus.avm_writedata_i;
                    be_d    = bus.avm_byteenable_i;
                    have_d  = 1'b1;
                end
            end
            ST_READ: begin
                if (bus.ctrl_dq_ie_i) begin
                    rdata_d = bus.ctrl_dq_ddr_in_i;
                    rdv_d   = 1'b1;
                    cnt_d   = '0;
                    words_d = words_q - 1'b1;
                    if (words_q == 8'd1) begin
                        state_d = ST_RECOV;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RECOV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOV: begin
                if (cnt_q == REC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset wins in every state, including mid-burst.
    always_ff @(posedge clk_x1_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            have_q    <= 1'b0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            have_q    <= have_d;
            rdata_q   <= rdata_d;
            rdv_q     <= rdv_d;
            err_q     <= err_d;
        end
    end

    // Bus outputs decoded from the current state; safe idle values everywhere else.
    always_comb begin
        bus.ctrl_csn_o          = 1'b1;
        bus.ctrl_ck_ddr_o       = 2'b00;
        bus.ctrl_dq_ddr_out_o   = 16'h0000;
        bus.ctrl_dq_oe_o        = 1'b0;
        bus.ctrl_rwds_ddr_out_o = 2'b00;
        bus.ctrl_rwds_oe_o      = 1'b0;
        bus.avm_waitrequest_o   = 1'b1;
        case (state_q)
            ST_IDLE: bus.avm_waitrequest_o = 1'b0;
            ST_CA: begin
                bus.ctrl_csn_o    = 1'b0;
                bus.ctrl_ck_ddr_o = 2'b10;
                bus.ctrl_dq_oe_o  = 1'b1;
                if (cnt_q == '0) begin
                    bus.ctrl_dq_ddr_out_o = ca_w[47:32];
                end else if (cnt_q == CNT_W'(1)) begin
                    bus.ctrl_dq_ddr_out_o = ca_w[31:16];
                end else begin
                    bus.ctrl_dq_ddr_out_o = ca_w[15:0];
                end
            end
            ST_LAT, ST_READ: begin
                bus.ctrl_csn_o    = 1'b0;
                bus.ctrl_ck_ddr_o = 2'b10;
            end
            ST_WRITE: begin
                // With no word held the clock stops and DQ/RWDS keep the last word.
                bus.ctrl_csn_o          = 1'b0;
                bus.ctrl_ck_ddr_o       = have_q ? 2'b10 : 2'b00;
                bus.ctrl_dq_ddr_out_o   = wdata_q;
                bus.ctrl_dq_oe_o        = 1'b1;
                bus.ctrl_rwds_ddr_out_o = {~be_q[1], ~be_q[0]};
                bus.ctrl_rwds_oe_o      = 1'b1;
                bus.avm_waitrequest_o   = !wr_more;
            end
            default: ;
        endcase
    end

    assign bus.ctrl_rstn_o         = (state_q != ST_INIT);
    assign bus.avm_readdata_o      = rdata_q;
    assign bus.avm_readdatavalid_o = rdv_q;
    assign bus.error_o             = err_q;
endmodule

// File: tb/tb_hyperram_ctrl.sv
// Directed testbench for hyperram_ctrl: reset, write, read, write stall with masking,
// single-word burst, read timeout and reset in the middle of a read burst.
module tb_hyperram_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    hyperram_if #(.ADDR_W(22)) bus ();

    hyperram_ctrl #(
        .ADDR_W(22), .LATENCY(4), .RESET_CYCLES(200), .RECOVERY(2), .TIMEOUT(64)
    ) dut (
        .clk_x1_i(clk),
        .rst_i   (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs are observed and inputs changed on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.avm_write_i      = 1'b0;
        bus.avm_read_i       = 1'b0;
        bus.avm_address_i    = '0;
        bus.avm_writedata_i  = '0;
        bus.avm_byteenable_i = 2'b11;
        bus.avm_burstcount_i = 8'd1;
        bus.ctrl_dq_ddr_in_i = '0;
        bus.ctrl_dq_ie_i     = 1'b0;
    endtask

    task automatic capture_ca(output logic [15:0] w0, output logic [15:0] w1,
                              output logic [15:0] w2);
        w0 = bus.ctrl_dq_ddr_out_o; tick();
        w1 = bus.ctrl_dq_ddr_out_o; tick();
        w2 = bus.ctrl_dq_ddr_out_o; tick();
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (bus.avm_waitrequest_o !== 1'b0 && n < 500) begin
            tick();
            n++;
        end
        timed_out = (n >= 500);
    endtask

    task automatic count_init(output int n, output bit viol);
        n = 0;
        viol = 1'b0;
        while (bus.ctrl_rstn_o === 1'b0 && n < 1000) begin
            if (bus.ctrl_csn_o !== 1'b1 || bus.ctrl_ck_ddr_o !== 2'b00 ||
                bus.avm_waitrequest_o !== 1'b1 || bus.ctrl_dq_oe_o !== 1'b0 ||
                bus.ctrl_rwds_oe_o !== 1'b0 || bus.avm_readdatavalid_o !== 1'b0 ||
                bus.error_o !== 1'b0)
                viol = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bit viol;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_init(n, viol);
        total++; if (n !== 200) begin bad++; $display("FAIL reset_rstn_len: got %0d want 200", n); end
        total++; if (viol !== 1'b0) begin bad++; $display("FAIL reset_outputs: got violation=%0d want 0", viol); end
        total++; if (bus.avm_waitrequest_o !== 1'b0) begin bad++; $display("FAIL reset_idle_wait: got %b want 0", bus.avm_waitrequest_o); end
        total++; if (bus.ctrl_csn_o !== 1'b1) begin bad++; $display("FAIL reset_idle_csn: got %b want 1", bus.ctrl_csn_o); end
    endtask

    task automatic test_write();
        logic [15:0] ca [3];
        logic [15:0] exp_ca [3] = '{16'h2000, 16'h0024, 16'h0003};
        int n;
        bit to;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL wr_idle: got timeout want idle"); end
        bus.avm_write_i = 1'b1; bus.avm_address_i = 22'h000123; bus.avm_burstcount_i = 8'd2;
        bus.avm_writedata_i = 16'hA1B2; bus.avm_byteenable_i = 2'b11;
        tick();
        total++; if (bus.avm_waitrequest_o !== 1'b1) begin bad++; $display("FAIL wr_ca_wait: got %b want 1", bus.avm_waitrequest_o); end
        bus.avm_writedata_i = 16'hC3D4;
        capture_ca(ca[0], ca[1], ca[2]);
        for (int i = 0; i < 3; i++) begin
            total++; if (ca[i] !== exp_ca[i]) begin bad++; $display("FAIL wr_ca%0d: got %h want %h", i, ca[i], exp_ca[i]); end
        end
        n = 0;
        while (bus.ctrl_dq_oe_o === 1'b0 && bus.ctrl_csn_o === 1'b0 && n < 32) begin tick(); n++; end
        total++; if (n !== 7) begin bad++; $display("FAIL wr_lat: got %0d want 7", n); end
        total++; if (bus.ctrl_dq_ddr_out_o !== 16'hA1B2 || bus.ctrl_ck_ddr_o !== 2'b10) begin bad++; $display("FAIL wr_word0: got %h ck=%b want a1b2 ck=10", bus.ctrl_dq_ddr_out_o, bus.ctrl_ck_ddr_o); end
        total++; if (bus.ctrl_rwds_oe_o !== 1'b1 || bus.ctrl_rwds_ddr_out_o !== 2'b00) begin bad++; $display("FAIL wr_rwds: got oe=%b rwds=%b want oe=1 rwds=00", bus.ctrl_rwds_oe_o, bus.ctrl_rwds_ddr_out_o); end
        total++; if (bus.avm_waitrequest_o !== 1'b0) begin bad++; $display("FAIL wr_accept: got %b want 0", bus.avm_waitrequest_o); end
        tick();
        total++; if (bus.ctrl_dq_ddr_out_o !== 16'hC3D4 || bus.ctrl_ck_ddr_o !== 2'b10) begin bad++; $display("FAIL wr_word1: got %h ck=%b want c3d4 ck=10", bus.ctrl_dq_ddr_out_o, bus.ctrl_ck_ddr_o); end
        bus.avm_write_i = 1'b0;
        tick();
        n = 0;
        while (bus.ctrl_csn_o === 1'b1 && bus.ctrl_ck_ddr_o === 2'b00 && bus.avm_waitrequest_o === 1'b1 && n < 16) begin tick(); n++; end
        total++; if (n !== 2) begin bad++; $display("FAIL wr_recovery: got %0d want 2", n); end
        total++; if (bus.avm_waitrequest_o !== 1'b0 || bus.ctrl_csn_o !== 1'b1) begin bad++; $display("FAIL wr_back_idle: got wait=%b csn=%b want 0 1", bus.avm_waitrequest_o, bus.ctrl_csn_o); end
    endtask

    task automatic test_read();
        logic [15:0] ca [3];
        logic [15:0] exp_ca [3] = '{16'hA000, 16'h0002, 16'h0000};
        bit          ie_tbl [10] = '{0, 1, 1, 0, 1, 1, 1, 0, 0, 0};
        logic [15:0] d_tbl  [10] = '{16'h0, 16'h1111, 16'h2222, 16'h0, 16'h3333, 16'h4444, 16'h5555, 16'h0, 16'h0, 16'h0};
        logic [15:0] exp_d  [4]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [15:0] got [$];
        bit          phase_bad = 1'b0;
        logic        csn_after = 1'b0;
        logic        wait_end  = 1'b1;
        bit          to;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL rd_idle: got timeout want idle"); end
        // Read and write together: the read must win.
        bus.avm_read_i = 1'b1; bus.avm_write_i = 1'b1;
        bus.avm_address_i = 22'h000010; bus.avm_burstcount_i = 8'd4;
        tick();
        bus.avm_read_i = 1'b0; bus.avm_write_i = 1'b0;
        capture_ca(ca[0], ca[1], ca[2]);
        for (int i = 0; i < 3; i++) begin
            total++; if (ca[i] !== exp_ca[i]) begin bad++; $display("FAIL rd_ca%0d: got %h want %h", i, ca[i], exp_ca[i]); end
        end
        repeat (7) tick();
        for (int i = 0; i < 10; i++) begin
            if (bus.avm_readdatavalid_o === 1'b1) got.push_back(bus.avm_readdata_o);
            if (i < 6 && (bus.ctrl_csn_o !== 1'b0 || bus.ctrl_ck_ddr_o !== 2'b10 ||
                          bus.ctrl_dq_oe_o !== 1'b0 || bus.ctrl_rwds_oe_o !== 1'b0))
                phase_bad = 1'b1;
            if (i == 6) csn_after = bus.ctrl_csn_o;
            if (i == 8) wait_end = bus.avm_waitrequest_o;
            bus.ctrl_dq_ie_i = ie_tbl[i];
            bus.ctrl_dq_ddr_in_i = d_tbl[i];
            tick();
        end
        bus.ctrl_dq_ie_i = 1'b0;
        total++; if (got.size() !== 4) begin bad++; $display("FAIL rd_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_d[i]) begin bad++; $display("FAIL rd_data%0d: got %h want %h", i, got[i], exp_d[i]); end
        end
        total++; if (phase_bad !== 1'b0) begin bad++; $display("FAIL rd_phase_outputs: got violation=%0d want 0", phase_bad); end
        total++; if (csn_after !== 1'b1) begin bad++; $display("FAIL rd_recovery_csn: got %b want 1", csn_after); end
        total++; if (wait_end !== 1'b0) begin bad++; $display("FAIL rd_back_idle: got %b want 0", wait_end); end
    endtask

    task automatic test_write_stall();
        logic [15:0] ca [3];
        logic [15:0] exp_tx [3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [15:0] tx [$];
        logic [1:0]  rwds_seen [9];
        int          stall = 0;
        bit          held_bad = 1'b0;
        logic        csn_end = 1'b0;
        bit          to;
        int          n;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL st_idle: got timeout want idle"); end
        bus.avm_write_i = 1'b1; bus.avm_address_i = 22'h000200; bus.avm_burstcount_i = 8'd3;
        bus.avm_writedata_i = 16'h1111; bus.avm_byteenable_i = 2'b11;
        tick();
        bus.avm_write_i = 1'b0;
        capture_ca(ca[0], ca[1], ca[2]);
        total++; if (ca[1] !== 16'h0040) begin bad++; $display("FAIL st_ca1: got %h want 0040", ca[1]); end
        n = 0;
        while (bus.ctrl_dq_oe_o === 1'b0 && bus.ctrl_csn_o === 1'b0 && n < 32) begin tick(); n++; end
        for (int i = 0; i < 9; i++) begin
            rwds_seen[i] = bus.ctrl_rwds_ddr_out_o;
            if (bus.ctrl_csn_o === 1'b0 && bus.ctrl_ck_ddr_o === 2'b10) tx.push_back(bus.ctrl_dq_ddr_out_o);
            if (bus.ctrl_csn_o === 1'b0 && bus.ctrl_ck_ddr_o === 2'b00) begin
                stall++;
                if (bus.ctrl_dq_ddr_out_o !== 16'h1111 || bus.ctrl_dq_oe_o !== 1'b1) held_bad = 1'b1;
            end
            if (i == 8) csn_end = bus.ctrl_csn_o;
            bus.avm_write_i = (i == 5 || i == 6);
            bus.avm_writedata_i  = (i == 5) ? 16'h2222 : 16'h3333;
            bus.avm_byteenable_i = (i == 5) ? 2'b11 : 2'b01;
            tick();
        end
        bus.avm_write_i = 1'b0;
        total++; if (stall !== 5) begin bad++; $display("FAIL st_stall_len: got %0d want 5", stall); end
        total++; if (held_bad !== 1'b0) begin bad++; $display("FAIL st_held: got violation=%0d want 0", held_bad); end
        total++; if (tx.size() !== 3) begin bad++; $display("FAIL st_tx_count: got %0d want 3", tx.size()); end
        for (int i = 0; i < 3 && i < tx.size(); i++) begin
            total++; if (tx[i] !== exp_tx[i]) begin bad++; $display("FAIL st_tx%0d: got %h want %h", i, tx[i], exp_tx[i]); end
        end
        total++; if (rwds_seen[0] !== 2'b00) begin bad++; $display("FAIL st_rwds_w1: got %b want 00", rwds_seen[0]); end
        total++; if (rwds_seen[7] !== 2'b10) begin bad++; $display("FAIL st_rwds_w3: got %b want 10", rwds_seen[7]); end
        total++; if (csn_end !== 1'b1) begin bad++; $display("FAIL st_csn_end: got %b want 1", csn_end); end
    endtask

    task automatic test_single_word();
        logic [15:0] ca [3];
        bit to;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL sw_idle: got timeout want idle"); end
        // Burst count 0 behaves as a single word.
        bus.avm_write_i = 1'b1; bus.avm_address_i = 22'h000007; bus.avm_burstcount_i = 8'd0;
        bus.avm_writedata_i = 16'h5A5A; bus.avm_byteenable_i = 2'b10;
        tick();
        bus.avm_write_i = 1'b0;
        capture_ca(ca[0], ca[1], ca[2]);
        total++; if (ca[2] !== 16'h0007 || ca[0] !== 16'h2000) begin bad++; $display("FAIL sw_ca: got %h/%h want 2000/0007", ca[0], ca[2]); end
        repeat (7) tick();
        total++; if (bus.ctrl_dq_ddr_out_o !== 16'h5A5A || bus.ctrl_rwds_ddr_out_o !== 2'b01) begin bad++; $display("FAIL sw_word: got %h rwds=%b want 5a5a rwds=01", bus.ctrl_dq_ddr_out_o, bus.ctrl_rwds_ddr_out_o); end
        total++; if (bus.avm_waitrequest_o !== 1'b1) begin bad++; $display("FAIL sw_wait: got %b want 1", bus.avm_waitrequest_o); end
        tick();
        total++; if (bus.ctrl_csn_o !== 1'b1 || bus.ctrl_dq_oe_o !== 1'b0) begin bad++; $display("FAIL sw_end: got csn=%b oe=%b want 1 0", bus.ctrl_csn_o, bus.ctrl_dq_oe_o); end
    endtask

    task automatic test_timeout();
        logic [15:0] ca [3];
        int n = 0;
        bit rdv_seen = 1'b0;
        bit to;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL to_idle: got timeout want idle"); end
        bus.avm_read_i = 1'b1; bus.avm_address_i = 22'h000040; bus.avm_burstcount_i = 8'd2;
        tick();
        bus.avm_read_i = 1'b0;
        capture_ca(ca[0], ca[1], ca[2]);
        repeat (7) tick();
        while (bus.error_o !== 1'b1 && n < 200) begin
            if (bus.avm_readdatavalid_o !== 1'b0) rdv_seen = 1'b1;
            tick();
            n++;
        end
        total++; if (n !== 64) begin bad++; $display("FAIL to_delay: got %0d want 64", n); end
        total++; if (bus.ctrl_csn_o !== 1'b1 || bus.ctrl_ck_ddr_o !== 2'b00) begin bad++; $display("FAIL to_csn: got csn=%b ck=%b want 1 00", bus.ctrl_csn_o, bus.ctrl_ck_ddr_o); end
        total++; if (rdv_seen !== 1'b0) begin bad++; $display("FAIL to_no_data: got %0d want 0", rdv_seen); end
        tick();
        total++; if (bus.error_o !== 1'b0) begin bad++; $display("FAIL to_pulse: got %b want 0", bus.error_o); end
        tick();
        total++; if (bus.avm_waitrequest_o !== 1'b0) begin bad++; $display("FAIL to_idle_after: got %b want 0", bus.avm_waitrequest_o); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] ca [3];
        logic [15:0] got [$];
        int n;
        bit viol;
        bit to;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL mr_idle: got timeout want idle"); end
        bus.avm_read_i = 1'b1; bus.avm_address_i = 22'h000000; bus.avm_burstcount_i = 8'd8;
        tick();
        bus.avm_read_i = 1'b0;
        capture_ca(ca[0], ca[1], ca[2]);
        repeat (7) tick();
        for (int i = 0; i < 4; i++) begin
            if (bus.avm_readdatavalid_o === 1'b1) got.push_back(bus.avm_readdata_o);
            bus.ctrl_dq_ie_i = 1'b1;
            bus.ctrl_dq_ddr_in_i = 16'hB000 + 16'(i);
            if (i == 3) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        total++; if (got.size() !== 3) begin bad++; $display("FAIL mr_words: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== 16'hB000 + 16'(i)) begin bad++; $display("FAIL mr_data%0d: got %h want %h", i, got[i], 16'hB000 + 16'(i)); end
        end
        total++; if (bus.ctrl_csn_o !== 1'b1 || bus.avm_readdatavalid_o !== 1'b0) begin bad++; $display("FAIL mr_stop: got csn=%b rdv=%b want 1 0", bus.ctrl_csn_o, bus.avm_readdatavalid_o); end
        bus.ctrl_dq_ie_i = 1'b0;
        count_init(n, viol);
        total++; if (n !== 200) begin bad++; $display("FAIL mr_rstn_len: got %0d want 200", n); end
        total++; if (viol !== 1'b0) begin bad++; $display("FAIL mr_init_outputs: got violation=%0d want 0", viol); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_write_stall();
        test_single_word();
        test_timeout();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
